host_rd_stream: RTL and testbench

Host readback streamer for the GPU data memory. Takes a (base address, length) burst request from the host interface, issues single-word reads on the memory's host read port only in cycles where the GPU load port is idle, and delivers the returned 64-bit words on a valid/ready stream with a last flag. Sits directly upstream of the data memory wrapper's host read port (B) and downstream of the host register/command block.

---
 rtl/host_rd_stream_if.sv | 34 +++
 rtl/host_rd_stream.sv | 158 +++++++++++++++
 tb/tb_host_rd_stream.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/host_rd_stream_if.sv
// Bundle of host command, memory port B and output stream signals for host_rd_stream.
// master is the streamer's view; slave is the view of the surrounding host, memory and sink.
interface host_rd_stream_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 9
);
  // host command side
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  // memory port B, plus the competing GPU load enable on port A
  logic              gpu_rd_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  // output stream
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  start, base_addr, len, gpu_rd_en, mem_rd_data, out_ready,
    output busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, len, gpu_rd_en, mem_rd_data, out_ready,
    input  busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/host_rd_stream.sv
// Host readback streamer: issues single-word reads on memory port B in GPU-idle cycles
// and returns the words on a valid/ready stream through a 3-entry FIFO.
module host_rd_stream #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 9
) (
  input logic               clk,
  input logic               rst_n,
  host_rd_stream_if.master  bus
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              done_q;

  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic              fifo_last_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              accept_c;
  logic              room_c;
  logic              issue_c;
  logic              final_issue_c;
  logic              push_c;
  logic              pop_c;
  logic              last_pop_c;
  logic              mem_rd_en_c;
  logic              busy_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stored words plus the one in flight may never exceed the FIFO depth
  assign room_c        = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
  assign accept_c      = (state_q == S_IDLE) && bus.start && (bus.len != '0);
  assign issue_c       = (state_q == S_RUN) && (remaining_q != '0) && !bus.gpu_rd_en && room_c;
  assign final_issue_c = issue_c && (remaining_q == LEN_W'(1));
  assign push_c        = inflight_q;
  assign pop_c         = (count_q != '0) && bus.out_ready;
  assign last_pop_c    = pop_c && fifo_last_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c)      state_d = S_RUN;
      S_RUN:   if (final_issue_c) state_d = S_DRAIN;
      S_DRAIN: if (last_pop_c)    state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs; the read enable follows the issue condition in the same cycle
  always_comb begin
    mem_rd_en_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_RUN: begin
        mem_rd_en_c = issue_c;
        busy_c      = 1'b1;
      end
      S_DRAIN: begin
        busy_c      = 1'b1;
      end
      default: begin
        mem_rd_en_c = 1'b0;
        busy_c      = 1'b0;
      end
    endcase
  end

  // Address / length counters and the one-deep in-flight tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q      <= bus.base_addr;
        remaining_q <= bus.len;
      end else if (issue_c) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - LEN_W'(1);
      end
      inflight_q      <= issue_c;
      inflight_last_q <= final_issue_c;
      done_q          <= (state_q == S_DRAIN) && last_pop_c;
    end
  end

  // Return FIFO; push and pop may coincide at any occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        fifo_data_q[wr_ptr_q] <= bus.mem_rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_q;
  assign bus.mem_rd_en   = mem_rd_en_c;
  assign bus.mem_rd_addr = addr_q;
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_data    = fifo_data_q[rd_ptr_q];
  assign bus.out_last    = (count_q != '0) && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_host_rd_stream.sv
// Directed bench for host_rd_stream: a memory model answers port-B reads and
// queued expected addresses and words are checked as the DUT issues and streams them.
module tb_host_rd_stream;

  logic clk;
  logic rst_n;

  host_rd_stream_if bus ();

  host_rd_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [256];

  // Memory port B with one cycle of read latency
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int n_issue;
  int first_hs;
  int last_hs;
  int done_cycle;
  int done_count = 0;
  logic got_done;
  logic done_busy;
  logic busy_seen;
  logic hold_pending = 1'b0;
  logic [63:0] hold_data;
  logic [31:0] gpu_mask = '0;
  logic [31:0] issue_mask;
  logic [7:0]  exp_addr_q [$];
  logic [64:0] exp_word_q [$];

  function automatic logic [63:0] word_of(input logic [7:0] a);
    return 64'(a) * 64'h0101;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then advance to just after the rising edge
  task automatic step();
    logic [64:0] w;
    logic [7:0]  a;
    @(negedge clk);
    if (bus.busy) busy_seen = 1'b1;
    if (hold_pending && bus.out_valid) chk("hold_data", bus.out_data, hold_data);
    hold_pending = bus.out_valid && !bus.out_ready;
    hold_data    = bus.out_data;
    if (bus.mem_rd_en) begin
      n_issue++;
      if (cyc_n < 32) issue_mask[cyc_n] = 1'b1;
      chk("rd_expected", 64'(exp_addr_q.size() != 0), 1);
      if (exp_addr_q.size() != 0) begin
        a = exp_addr_q.pop_front();
        chk("rd_addr", 64'(bus.mem_rd_addr), 64'(a));
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      if (first_hs < 0) first_hs = cyc_n;
      last_hs = cyc_n;
      chk("word_expected", 64'(exp_word_q.size() != 0), 1);
      if (exp_word_q.size() != 0) begin
        w = exp_word_q.pop_front();
        chk("out_data", bus.out_data, w[63:0]);
        chk("out_last", 64'(bus.out_last), 64'(w[64]));
      end
    end
    if (bus.done) begin
      done_count++;
      got_done   = 1'b1;
      done_cycle = cyc_n;
      done_busy  = bus.busy;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    bus.gpu_rd_en = (cyc_n < 32) ? gpu_mask[cyc_n] : 1'b0;
  endtask

  // Drive a start pulse in cycle 0 and queue the expected reads and words
  task automatic start_burst(input logic [7:0] base, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      exp_addr_q.push_back(a);
      exp_word_q.push_back({(i == n - 1), word_of(a)});
    end
    n_issue    = 0;
    first_hs   = -1;
    last_hs    = -1;
    issue_mask = '0;
    busy_seen  = 1'b0;
    got_done   = 1'b0;
    cyc_n      = 0;
    bus.gpu_rd_en = gpu_mask[0];
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = 9'(n);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    got_done = 1'b0;
    while (!got_done && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, 64'(got_done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      64'(bus.busy), 0);
    chk({tag, "_done"},      64'(bus.done), 0);
    chk({tag, "_mem_rd_en"}, 64'(bus.mem_rd_en), 0);
    chk({tag, "_rd_addr"},   64'(bus.mem_rd_addr), 0);
    chk({tag, "_valid"},     64'(bus.out_valid), 0);
    chk({tag, "_last"},      64'(bus.out_last), 0);
    chk({tag, "_data"},      bus.out_data, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word_of(8'(i));
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.gpu_rd_en = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Basic 4-word burst at full throughput
    start_burst(8'h10, 4);
    wait_done("t1", 20);
    chk("t1_issue_cycles", 64'(issue_mask), 64'h1E);
    chk("t1_first_word",   64'(first_hs), 3);
    chk("t1_last_word",    64'(last_hs), 6);
    chk("t1_done_cycle",   64'(done_cycle), 7);
    chk("t1_done_busy",    64'(done_busy), 0);
    step();

    // GPU steals cycles 2 and 3
    gpu_mask = 32'h0000_000C;
    start_burst(8'h10, 4);
    wait_done("t2", 20);
    gpu_mask = '0;
    chk("t2_issue_cycles", 64'(issue_mask), 64'h72);
    chk("t2_first_word",   64'(first_hs), 3);
    chk("t2_last_word",    64'(last_hs), 8);
    chk("t2_done_cycle",   64'(done_cycle), 9);
    step();

    // Address wrap 0xFE -> 0x01
    start_burst(8'hFE, 4);
    wait_done("t3", 20);
    chk("t3_done_cycle", 64'(done_cycle), 7);
    chk("t3_reads",      64'(n_issue), 4);
    step();

    // Backpressure for 10 cycles
    bus.out_ready = 1'b0;
    start_burst(8'h20, 8);
    repeat (10) step();
    chk("t4_reads_stalled", 64'(n_issue), 3);
    chk("t4_valid_stalled", 64'(bus.out_valid), 1);
    chk("t4_head_word",     bus.out_data, word_of(8'h20));
    bus.out_ready = 1'b1;
    wait_done("t4", 60);
    chk("t4_reads_total", 64'(n_issue), 8);
    chk("t4_words_left",  64'(exp_word_q.size()), 0);
    step();

    // Zero-length start is a no-op
    begin
      int dc;
      dc = done_count;
      start_burst(8'h40, 0);
      repeat (5) step();
      chk("t5_reads",     64'(n_issue), 0);
      chk("t5_busy_seen", 64'(busy_seen), 0);
      chk("t5_no_done",   64'(done_count - dc), 0);
    end

    // Start during a burst is ignored
    start_burst(8'h30, 3);
    step();
    bus.start     = 1'b1;
    bus.base_addr = 8'h80;
    bus.len       = 9'd5;
    step();
    bus.start = 1'b0;
    wait_done("t6", 20);
    repeat (3) step();
    chk("t6_reads",      64'(n_issue), 3);
    chk("t6_words_left", 64'(exp_word_q.size()), 0);
    chk("t6_busy_after", 64'(bus.busy), 0);

    // Reset with two words held in the FIFO
    bus.out_ready = 1'b0;
    start_burst(8'h60, 8);
    repeat (3) step();
    chk("t7_valid_before_rst", 64'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_word_q.delete();
    hold_pending  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    start_burst(8'h55, 1);
    wait_done("t8", 10);
    chk("t8_reads",      64'(n_issue), 1);
    chk("t8_first_word", 64'(first_hs), 3);
    chk("t8_done_cycle", 64'(done_cycle), 4);
    chk("t8_words_left", 64'(exp_word_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
